// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory arbiter.
//   size_e    - access size encoding as seen on the requester ports
//   state_e   - arbiter FSM states
//   req_t     - one requester's payload, bundled for muxing
//   lane_mask - byte-lane write mask for a sub-word store
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_e;

    typedef struct packed {
        logic        we;
        size_e       size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Requester id latched for an RMW so the completion goes to the right port.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // Mask covering the bytes a store of the given size touches at this lane.
    function automatic logic [31:0] lane_mask(size_e size, logic [1:0] lane);
        logic [31:0] base;
        case (size)
            SZ_BYTE: base = 32'h0000_00FF;
            SZ_HALF: base = 32'h0000_FFFF;
            default: base = 32'hFFFF_FFFF;
        endcase
        return base << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_prio.sv
// dmem_rr_prio: grant logic for the two memory requesters.
// cpu wins by default; dma wins when it is alone or after it has waited
// STARVE_LIMIT consecutive cycles. Grants are only issued while arb_en_i
// is high (the FSM is idle), but waiting cycles are counted regardless.
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   arb_en_i              arbitration allowed this cycle
//   cpu_req_i, dma_req_i  request valids
//   grant_cpu_o/_dma_o    one-hot (or zero) grant
module dmem_rr_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic arb_en_i,
    input  logic cpu_req_i,
    input  logic dma_req_i,
    output logic grant_cpu_o,
    output logic grant_dma_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starved;

    assign starved     = (starve_cnt_q == LIMIT);
    assign grant_dma_o = arb_en_i && dma_req_i && (!cpu_req_i || starved);
    assign grant_cpu_o = arb_en_i && cpu_req_i && !grant_dma_o;

    // Saturating wait counter; an RMW cycle with dma pending counts as waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dma_req_i || grant_dma_o) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port word memory between the cpu MEM stage
// and a dma/loader port. Loads and word stores complete in the grant cycle;
// byte/half stores become a two-cycle read-modify-write because the memory
// only has a whole-word write enable. Misaligned, illegal-size and
// out-of-range accesses complete immediately with err.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   cpu_*_i / dma_*_i              request: req, we, size, byte addr, wdata
//   cpu_*_o / dma_*_o              ready pulse, err (with ready), rvalid
//   rsp_rdata_o                    registered load word, valid with rvalid
//   mem_we_o, mem_a_o, mem_wd_o    memory write enable, word index, write data
//   mem_rd_i                       combinational memory read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [1:0]            cpu_size_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_ready_o,
    output logic                  cpu_err_o,
    output logic                  cpu_rvalid_o,
    input  logic                  dma_req_i,
    input  logic                  dma_we_i,
    input  logic [1:0]            dma_size_i,
    input  logic [31:0]           dma_addr_i,
    input  logic [DATA_WIDTH-1:0] dma_wdata_i,
    output logic                  dma_ready_o,
    output logic                  dma_err_o,
    output logic                  dma_rvalid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_a_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    req_t   cpu_r, dma_r, sel;
    logic   grant_cpu, grant_dma, granted, sel_err;
    logic   sel_owner;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] wsh_q, wsh_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] mem_a_q;
    logic [31:0] rdata_q, rdata_d;
    logic        rv_cpu_q, rv_cpu_d, rv_dma_q, rv_dma_d;

    logic        done, err, done_owner;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd;

    assign cpu_r = '{we: cpu_we_i, size: size_e'(cpu_size_i), addr: cpu_addr_i, wdata: cpu_wdata_i};
    assign dma_r = '{we: dma_we_i, size: size_e'(dma_size_i), addr: dma_addr_i, wdata: dma_wdata_i};

    dmem_rr_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .arb_en_i   (state_q == S_IDLE),
        .cpu_req_i  (cpu_req_i),
        .dma_req_i  (dma_req_i),
        .grant_cpu_o(grant_cpu),
        .grant_dma_o(grant_dma)
    );

    assign granted   = grant_cpu || grant_dma;
    assign sel_owner = grant_dma ? OWNER_DMA : OWNER_CPU;
    assign sel       = grant_dma ? dma_r : cpu_r;

    // Any word index bit at or above ADDRESS_WIDTH means out of range.
    assign sel_err = (sel.size == SZ_BAD)
                  || (sel.size == SZ_HALF && sel.addr[0])
                  || (sel.size == SZ_WORD && sel.addr[1:0] != 2'b00)
                  || ((sel.addr[31:2] >> ADDRESS_WIDTH) != 30'd0);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        idx_d      = idx_q;
        wsh_d      = wsh_q;
        mask_d     = mask_q;
        rdata_d    = rdata_q;
        rv_cpu_d   = 1'b0;
        rv_dma_d   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        done_owner = sel_owner;
        mem_we     = 1'b0;
        mem_wd     = 32'd0;
        mem_a      = mem_a_q;   // address bus holds when nothing is granted

        case (state_q)
            S_IDLE: begin
                if (granted) begin
                    if (sel_err) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else begin
                        mem_a = {2'b00, sel.addr[31:2]};
                        if (!sel.we) begin
                            done     = 1'b1;
                            rdata_d  = mem_rd_i;
                            rv_cpu_d = (sel_owner == OWNER_CPU);
                            rv_dma_d = (sel_owner == OWNER_DMA);
                        end else if (sel.size == SZ_WORD) begin
                            done   = 1'b1;
                            mem_we = 1'b1;
                            mem_wd = sel.wdata;
                        end else begin
                            // Sub-word store: capture everything now so the
                            // requester may drop its request during RMW.
                            owner_d = sel_owner;
                            idx_d   = {2'b00, sel.addr[31:2]};
                            wsh_d   = sel.wdata << {sel.addr[1:0], 3'b000};
                            mask_d  = lane_mask(sel.size, sel.addr[1:0]);
                            state_d = S_RMW;
                        end
                    end
                end
            end
            S_RMW: begin
                mem_a      = idx_q;
                mem_we     = 1'b1;
                mem_wd     = (mem_rd_i & ~mask_q) | (wsh_q & mask_q);
                done       = 1'b1;
                done_owner = owner_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            owner_q  <= OWNER_CPU;
            idx_q    <= '0;
            wsh_q    <= '0;
            mask_q   <= '0;
            mem_a_q  <= '0;
            rdata_q  <= '0;
            rv_cpu_q <= 1'b0;
            rv_dma_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            idx_q    <= idx_d;
            wsh_q    <= wsh_d;
            mask_q   <= mask_d;
            mem_a_q  <= mem_a;
            rdata_q  <= rdata_d;
            rv_cpu_q <= rv_cpu_d;
            rv_dma_q <= rv_dma_d;
        end
    end

    // Outputs are forced low while reset is held, which also kills the write
    // of an RMW caught by reset.
    assign cpu_ready_o  = rst_n_i && done && (done_owner == OWNER_CPU);
    assign dma_ready_o  = rst_n_i && done && (done_owner == OWNER_DMA);
    assign cpu_err_o    = cpu_ready_o && err;
    assign dma_err_o    = dma_ready_o && err;
    assign cpu_rvalid_o = rst_n_i && rv_cpu_q;
    assign dma_rvalid_o = rst_n_i && rv_dma_q;
    assign rsp_rdata_o  = rst_n_i ? rdata_q : '0;
    assign mem_we_o     = rst_n_i && mem_we;
    assign mem_a_o      = rst_n_i ? mem_a : 32'd0;
    assign mem_wd_o     = rst_n_i ? mem_wd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk, rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [1:0]  cpu_size, dma_size;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ready, cpu_err, cpu_rvalid, dma_ready, dma_err, dma_rvalid;
    logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_size_i(cpu_size),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ready_o(cpu_ready), .cpu_err_o(cpu_err), .cpu_rvalid_o(cpu_rvalid),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_size_i(dma_size),
        .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_ready_o(dma_ready), .dma_err_o(dma_err), .dma_rvalid_o(dma_rvalid),
        .rsp_rdata_o(rsp_rdata), .mem_we_o(mem_we), .mem_a_o(mem_a),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    // Single-port word memory: combinational read, synchronous write.
    assign mem_rd = mem[mem_a[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_size = s; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dma(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        dma_req = r; dma_we = w; dma_size = s; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        dma(0, 0, 2'b10, 0, 0);
        // request present during reset must not leak through
        cpu(1, 1, 2'b10, 32'h10, 32'h1111_1111);
        @(negedge clk); @(negedge clk); #2;
        chk("rst_ready",  cpu_ready, 0);
        chk("rst_err",    cpu_err, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_rdata",  rsp_rdata, 0);
        chk("rst_we",     mem_we, 0);
        chk("rst_a",      mem_a, 0);
        chk("rst_wd",     mem_wd, 0);

        // word store then load
        @(negedge clk); rst_n = 1'b1; cpu(1, 1, 2'b10, 32'h10, 32'hDEAD_BEEF); #2;
        chk("wst_ready", cpu_ready, 1);
        chk("wst_we",    mem_we, 1);
        chk("wst_a",     mem_a, 4);
        chk("wst_wd",    mem_wd, 32'hDEAD_BEEF);
        chk("wst_err",   cpu_err, 0);
        @(negedge clk); cpu(1, 0, 2'b10, 32'h10, 0); #2;
        chk("ld_ready",  cpu_ready, 1);
        chk("ld_we",     mem_we, 0);
        chk("ld_a",      mem_a, 4);
        chk("ld_rv_t",   cpu_rvalid, 0);
        @(negedge clk); cpu(0, 0, 2'b10, 0, 0); #2;
        chk("ld_rv_t1",  cpu_rvalid, 1);
        chk("ld_data",   rsp_rdata, 32'hDEAD_BEEF);
        chk("ld_idle_rdy", cpu_ready, 0);
        chk("idle_a_hold", mem_a, 4);
        @(negedge clk); #2;
        chk("ld_rv_once", cpu_rvalid, 0);

        // byte store 0x11 <- AA
        @(negedge clk); cpu(1, 1, 2'b00, 32'h11, 32'h0000_00AA); #2;
        chk("bst_c1_rdy", cpu_ready, 0);
        chk("bst_c1_we",  mem_we, 0);
        @(negedge clk); #2;
        chk("bst_c2_rdy", cpu_ready, 1);
        chk("bst_c2_we",  mem_we, 1);
        chk("bst_c2_a",   mem_a, 4);
        chk("bst_c2_wd",  mem_wd, 32'hDEAD_AAEF);
        // half store 0x12 <- 1234
        @(negedge clk); cpu(1, 1, 2'b01, 32'h12, 32'h0000_1234); #2;
        chk("hst_c1_rdy", cpu_ready, 0);
        @(negedge clk); #2;
        chk("hst_c2_rdy", cpu_ready, 1);
        chk("hst_c2_wd",  mem_wd, 32'h1234_AAEF);
        @(negedge clk); cpu(0, 0, 2'b10, 0, 0); #2;
        chk("hst_mem", mem[4], 32'h1234_AAEF);

        // rejected accesses
        @(negedge clk); cpu(1, 1, 2'b01, 32'h13, 32'hFFFF); #2;
        chk("e_half_rdy", cpu_ready, 1);
        chk("e_half_err", cpu_err, 1);
        chk("e_half_we",  mem_we, 0);
        @(negedge clk); cpu(1, 0, 2'b10, 32'h12, 0); #2;
        chk("e_word_err", cpu_err, 1);
        chk("e_word_we",  mem_we, 0);
        @(negedge clk); cpu(1, 0, 2'b10, 32'h400, 0); #2;
        chk("e_word_rv",  cpu_rvalid, 0);
        chk("e_oor_rdy",  cpu_ready, 1);
        chk("e_oor_err",  cpu_err, 1);
        @(negedge clk); cpu(1, 1, 2'b11, 32'h10, 32'h5); #2;
        chk("e_oor_rv",   cpu_rvalid, 0);
        chk("e_size_err", cpu_err, 1);
        chk("e_size_we",  mem_we, 0);
        @(negedge clk); cpu(0, 0, 2'b10, 0, 0); #2;
        chk("e_quiet_rdy", cpu_ready, 0);
        chk("e_mem_kept",  mem[4], 32'h1234_AAEF);

        // starvation: both load continuously
        @(negedge clk);
        cpu(1, 0, 2'b10, 32'h10, 0);
        dma(1, 0, 2'b10, 32'h10, 0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #2;
            chk($sformatf("stv_dma_rdy%0d", i), dma_ready, (i == 4 || i == 9));
            chk($sformatf("stv_cpu_rdy%0d", i), cpu_ready, !(i == 4 || i == 9));
            chk($sformatf("stv_cpu_rv%0d", i),  cpu_rvalid, (i > 0 && i != 5));
            chk($sformatf("stv_dma_rv%0d", i),  dma_rvalid, (i == 5));
        end
        chk("stv_rdata", rsp_rdata, 32'h1234_AAEF);
        @(negedge clk); cpu(0, 0, 2'b10, 0, 0); dma(0, 0, 2'b10, 0, 0); #2;
        chk("stv_dma_rv_end", dma_rvalid, 1);
        chk("stv_cpu_rv_end", cpu_rvalid, 0);

        // dma byte store; cpu arrives during RMW and must wait
        @(negedge clk); dma(1, 1, 2'b00, 32'h10, 32'h55); #2;
        chk("drmw_c1_rdy", dma_ready, 0);
        chk("drmw_c1_we",  mem_we, 0);
        @(negedge clk); cpu(1, 0, 2'b10, 32'h10, 0); #2;
        chk("drmw_c2_rdy", dma_ready, 1);
        chk("drmw_c2_cpu", cpu_ready, 0);
        chk("drmw_c2_we",  mem_we, 1);
        chk("drmw_c2_wd",  mem_wd, 32'h1234_AA55);
        @(negedge clk); dma(0, 0, 2'b10, 0, 0); #2;
        chk("drmw_c3_cpu", cpu_ready, 1);
        chk("drmw_c3_dma", dma_ready, 0);
        chk("drmw_c3_we",  mem_we, 0);
        @(negedge clk); cpu(0, 0, 2'b10, 0, 0); #2;
        chk("drmw_rv",   cpu_rvalid, 1);
        chk("drmw_data", rsp_rdata, 32'h1234_AA55);

        // reset during RMW
        @(negedge clk); cpu(1, 1, 2'b01, 32'h10, 32'hBEEF); #2;
        chk("rrmw_c1_rdy", cpu_ready, 0);
        @(negedge clk); rst_n = 1'b0; #2;
        chk("rrmw_we",  mem_we, 0);
        chk("rrmw_rdy", cpu_ready, 0);
        chk("rrmw_a",   mem_a, 0);
        chk("rrmw_wd",  mem_wd, 0);
        @(negedge clk); cpu(0, 0, 2'b10, 0, 0); #2;
        chk("rrmw_mem",   mem[4], 32'h1234_AA55);
        chk("rrmw_rdata", rsp_rdata, 0);
        chk("rrmw_we2",   mem_we, 0);
        @(negedge clk); rst_n = 1'b1; cpu(1, 0, 2'b10, 32'h10, 0); #2;
        chk("post_ld_rdy", cpu_ready, 1);
        chk("post_ld_we",  mem_we, 0);
        chk("post_ld_a",   mem_a, 4);
        @(negedge clk); cpu(0, 0, 2'b10, 0, 0); #2;
        chk("post_rv",   cpu_rvalid, 1);
        chk("post_data", rsp_rdata, 32'h1234_AA55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Sits in front of the single-port, word-wide data memory. Shares the memory between two requesters: the pipeline MEM stage (cpu) and a loader/DMA port (dma). Turns byte and halfword stores into read-modify-write sequences, because the memory has only a whole-word write enable. Rejects misaligned and out-of-range accesses.

Parameters:
DATA_WIDTH, 32, data word width; fixed at 32 for byte/half lane logic.
ADDRESS_WIDTH, 8, memory word-index width; the memory holds 2**ADDRESS_WIDTH words.
STARVE_LIMIT, 4, number of consecutive waiting cycles after which dma is forced to win.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
cpu_req  in  1  cpu request valid; held stable until cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  00=byte, 01=half, 10=word; 11 is illegal and is treated as an error
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
cpu_ready  out  1  one-cycle pulse when the request completes
cpu_err  out  1  valid with cpu_ready; access rejected
cpu_rvalid  out  1  load data valid on rsp_rdata
dma_req, dma_we, dma_size, dma_addr, dma_wdata, dma_ready, dma_err, dma_rvalid  same as the cpu_* ports, for the dma port
rsp_rdata  out  32  shared registered load data (raw aligned word)
mem_we  out  1  to memory WE
mem_a  out  32  to memory A (word index)
mem_wd  out  32  to memory WD
mem_rd  in  32  from memory RD (combinational read)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n=0, every output is 0: ready, err, rvalid, rsp_rdata, mem_we, mem_a, mem_wd. The FSM returns to IDLE and starve_cnt clears. Reset during RMW abandons the write; no mem_we is issued.
- FSM has 2 states, IDLE and RMW.
- IDLE arbitration:
  - cpu wins by default.
  - dma wins when only dma requests, or when starve_cnt==STARVE_LIMIT.
- starve_cnt:
  - Increments, saturating, on each cycle dma_req=1 and dma is not granted. This includes cycles spent in RMW.
  - Clears when dma is granted or dma_req=0.
- Address mapping: mem_a = {2'b0, addr[31:2]}. Lane = addr[1:0].
- Error check, done in IDLE on the granted request. err=1 when any of:
  - size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= 2**ADDRESS_WIDTH.
  - On error: ready=1 and err=1 the same cycle, mem_we=0, no rvalid, FSM stays IDLE.
- Load, granted at cycle T:
  - mem_a driven and ready=1 at T.
  - rsp_rdata <= mem_rd at the T edge, so rsp_rdata and rvalid are valid at T+1 for one cycle.
  - Back-to-back loads sustain 1 per cycle.
- Word store: mem_we=1, mem_wd=wdata, ready=1 at T. Single cycle.
- Byte/half store:
  - At T, latch requester id, word index, wdata shifted to lane (wdata << 8*lane), and mask (0xFF or 0xFFFF shifted to lane). ready=0. Go to RMW.
  - In RMW at T+1: mem_a = latched index, mem_we=1, mem_wd = (mem_rd & ~mask) | (shifted & mask). ready=1 to the owner. Return to IDLE.
  - No new grant is made during RMW.
  - Throughput is 1 sub-word store per 2 cycles.
- Outputs when idle or no grant: mem_we=0, mem_wd=0, mem_a holds its last value.
- Requesters must hold req and payload until ready. Dropping req before ready is illegal except during an RMW, whose latched values make the drop harmless.
- A load to an address being RMW-written in the same cycle cannot occur, since there is one port and one grant per cycle.

Decomposition:
- Package dmem_pkg:
  - enum size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD};
  - enum state_e {S_IDLE, S_RMW};
  - typedef req_t struct {we, size, addr, wdata};
  - function lane_mask(size, lane).
- One natural sub-module, dmem_rr_prio: the starvation counter plus grant logic, outputs grant_cpu and grant_dma. The FSM and datapath stay in the top level.

Test Plan:
- Word store cpu addr 0x10, wdata 0xDEADBEEF; then load 0x10 -> mem_a=4, mem_we=1 one cycle; load gives rsp_rdata=0xDEADBEEF with cpu_rvalid one cycle after cpu_ready.
- Memory word 4 = 0xDEADBEEF; byte store addr 0x11, wdata 0xAA -> 2 cycles, ready on 2nd; word 4 becomes 0xDEADAABEF's lane1 replaced = 0xDEADAAEF. Half store addr 0x12, wdata 0x1234 -> 0x1234AAEF.
- Misaligned half addr 0x13 and word addr 0x12; addr 0x400 with ADDRESS_WIDTH=8 -> ready=1, err=1, mem_we never 1, no rvalid.
- cpu and dma both request continuous loads -> cpu granted 4 cycles, dma granted on the 5th, then cpu resumes; starve_cnt returns to 0.
- dma byte store during a cpu request -> cpu waits through RMW; cpu granted the cycle after dma_ready.
- rst_n=0 in RMW cycle -> no mem_we, all outputs 0 next cycle, memory word unchanged.
